// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

    // Sequencer states; the encoding is free, only the names matter.
    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2,
        FAULT  = 2'd3
    } state_t;

    // Byte stride between consecutive instruction words.
    localparam logic [31:0] INSTR_BYTES = 32'd4;

    // Canonical RISC-V no-op (addi x0, x0, 0).
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_addr_check.sv
// Combinational word-alignment and range check for a word-addressed memory.
// Reusable for any memory whose legal byte range is 0 .. WORDS*4-1.
module fetch_addr_check #(
    parameter int unsigned IMEM_WORDS = 256
) (
    input  logic [31:0] addr,
    output logic        legal
);

    // One extra bit so a depth of 2^30 words still yields a correct limit.
    localparam logic [32:0] LIMIT = 33'(IMEM_WORDS) * 33'd4;

    // Legal when word aligned and below the end of memory; compared on all 32 bits.
    assign legal = (addr[1:0] == 2'b00) && ({1'b0, addr} < LIMIT);

endmodule

// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: owns the PC, drives the instruction memory
// address, registers the returned word with its PC and hands it to decode
// over a valid/ready handshake. Handles redirects, halt and address faults.
module fetch_controller
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt_req,
    output logic        halted,
    output logic        fault,
    output logic [31:0] fault_pc
);

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic        pc_legal;
    logic        redirect_legal;
    logic        consumed;
    logic        slot_free;
    logic        do_fetch;
    logic        do_redirect;
    logic        go_fault;
    logic        drop_valid;
    logic [31:0] fault_addr;

    fetch_addr_check #(.IMEM_WORDS(IMEM_WORDS)) u_pc_check (
        .addr  (pc),
        .legal (pc_legal)
    );

    fetch_addr_check #(.IMEM_WORDS(IMEM_WORDS)) u_redirect_check (
        .addr  (redirect_pc),
        .legal (redirect_legal)
    );

    // The memory address is the PC register itself, no extra logic in the path.
    assign imem_addr = pc;

    // Decode takes the held word this cycle; the slot can refill in the same edge.
    assign consumed  = if_valid && if_ready;
    assign slot_free = !if_valid || if_ready;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (rst) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and per-cycle action decode; redirect outranks halt and fetch.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case leaves one unassigned and no latch is inferred.
        state_next  = state;
        do_fetch    = 1'b0;
        do_redirect = 1'b0;
        go_fault    = 1'b0;
        drop_valid  = 1'b0;
        fault_addr  = pc;

        case (state)
            BOOT: begin
                state_next = RUN;
            end

            RUN, HALTED: begin
                if (redirect) begin
                    do_redirect = 1'b1;
                    drop_valid  = 1'b1;
                    if (!redirect_legal) begin
                        go_fault   = 1'b1;
                        fault_addr = redirect_pc;
                        state_next = FAULT;
                    end else begin
                        state_next = halt_req ? HALTED : RUN;
                    end
                end else if (state == HALTED || halt_req) begin
                    // No fetch while halting or halted; only let decode drain.
                    drop_valid = consumed;
                    state_next = halt_req ? HALTED : RUN;
                end else if (slot_free) begin
                    if (pc_legal) begin
                        do_fetch = 1'b1;
                    end else begin
                        go_fault   = 1'b1;
                        drop_valid = 1'b1;
                        state_next = FAULT;
                    end
                end
            end

            FAULT: begin
                drop_valid = 1'b1;
            end

            default: begin
                state_next = BOOT;
            end
        endcase
    end

    // PC register: redirect target, sequential advance, or hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (do_redirect) begin
            pc <= redirect_pc;
        end else if (do_fetch) begin
            pc <= pc + INSTR_BYTES;
        end
    end

    // Output slot: capture on fetch, clear when drained or discarded, else hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_valid <= 1'b0;
            if_instr <= '0;
            if_pc    <= '0;
        end else if (do_fetch) begin
            if_valid <= 1'b1;
            if_instr <= imem_instr;
            if_pc    <= pc;
        end else if (drop_valid) begin
            if_valid <= 1'b0;
        end
    end

    // Registered status: halted mirrors the HALTED state, fault is sticky.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            halted   <= 1'b0;
            fault    <= 1'b0;
            fault_pc <= '0;
        end else begin
            halted <= (state_next == HALTED);
            if (go_fault) begin
                fault    <= 1'b1;
                fault_pc <= fault_addr;
            end
        end
    end

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller: directed scenarios with fixed
// expected values, then random traffic compared against a behavioural model.
module tb_fetch_controller;
    import fetch_pkg::*;

    localparam int unsigned WORDS   = 256;
    localparam int unsigned S_WORDS = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    // Main instance (default depth)
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        if_valid;
    logic        if_ready = 1'b1;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        halt_req = 1'b0;
    logic        halted;
    logic        fault;
    logic [31:0] fault_pc;

    // Small instance (4-word memory) for the end-of-memory case
    logic [31:0] s_imem_addr;
    logic [31:0] s_imem_instr;
    logic        s_if_valid;
    logic        s_if_ready = 1'b1;
    logic [31:0] s_if_instr;
    logic [31:0] s_if_pc;
    logic        s_redirect = 1'b0;
    logic [31:0] s_redirect_pc = '0;
    logic        s_halt_req = 1'b1;
    logic        s_halted;
    logic        s_fault;
    logic [31:0] s_fault_pc;

    logic [31:0] mem [WORDS];

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model of the architecturally visible behaviour
    bit          m_booting;
    bit          m_halted;
    bit          m_faulted;
    bit          m_valid;
    logic [31:0] m_pc;
    logic [31:0] m_if_pc;
    logic [31:0] m_if_instr;
    logic [31:0] m_fault_pc;

    always #5 clk = ~clk;

    assign imem_instr   = mem[imem_addr[9:2]];
    assign s_imem_instr = mem[s_imem_addr[9:2]];

    fetch_controller #(.RESET_PC(32'h0), .IMEM_WORDS(WORDS)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_addr   (imem_addr),
        .imem_instr  (imem_instr),
        .if_valid    (if_valid),
        .if_ready    (if_ready),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt_req    (halt_req),
        .halted      (halted),
        .fault       (fault),
        .fault_pc    (fault_pc)
    );

    fetch_controller #(.RESET_PC(32'h0), .IMEM_WORDS(S_WORDS)) dut_small (
        .clk         (clk),
        .rst         (rst),
        .imem_addr   (s_imem_addr),
        .imem_instr  (s_imem_instr),
        .if_valid    (s_if_valid),
        .if_ready    (s_if_ready),
        .if_instr    (s_if_instr),
        .if_pc       (s_if_pc),
        .redirect    (s_redirect),
        .redirect_pc (s_redirect_pc),
        .halt_req    (s_halt_req),
        .halted      (s_halted),
        .fault       (s_fault),
        .fault_pc    (s_fault_pc)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit is_legal(input logic [31:0] a, input int unsigned words);
        return (a % 4 == 0) && (64'(a) < 64'(words) * 64'd4);
    endfunction

    task automatic model_reset();
        m_booting  = 1'b1;
        m_halted   = 1'b0;
        m_faulted  = 1'b0;
        m_valid    = 1'b0;
        m_pc       = 32'h0;
        m_if_pc    = 32'h0;
        m_if_instr = 32'h0;
        m_fault_pc = 32'h0;
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        bit taken;
        taken = m_valid && if_ready;
        if (m_booting) begin
            m_booting = 1'b0;
        end else if (m_faulted) begin
            m_valid = 1'b0;
        end else if (redirect) begin
            m_valid = 1'b0;
            m_pc    = redirect_pc;
            if (!is_legal(redirect_pc, WORDS)) begin
                m_faulted  = 1'b1;
                m_fault_pc = redirect_pc;
                m_halted   = 1'b0;
            end else begin
                m_halted = halt_req;
            end
        end else if (m_halted || halt_req) begin
            if (taken) m_valid = 1'b0;
            m_halted = halt_req;
        end else if (!m_valid || if_ready) begin
            if (is_legal(m_pc, WORDS)) begin
                m_if_instr = mem[m_pc[9:2]];
                m_if_pc    = m_pc;
                m_valid    = 1'b1;
                m_pc       = m_pc + 32'd4;
            end else begin
                m_faulted  = 1'b1;
                m_fault_pc = m_pc;
                m_valid    = 1'b0;
            end
        end
    endtask

    task automatic compare_model();
        check("model.if_valid",  32'(if_valid), 32'(m_valid));
        check("model.if_pc",     if_pc,         m_if_pc);
        check("model.if_instr",  if_instr,      m_if_instr);
        check("model.imem_addr", imem_addr,     m_pc);
        check("model.halted",    32'(halted),   32'(m_halted));
        check("model.fault",     32'(fault),    32'(m_faulted));
        check("model.fault_pc",  fault_pc,      m_fault_pc);
    endtask

    // One clock: model predicts, DUT clocks, outputs sampled 1 time unit later.
    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        compare_model();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".if_valid"},  32'(if_valid), 32'h0);
        check({tag, ".if_pc"},     if_pc,         32'h0);
        check({tag, ".if_instr"},  if_instr,      32'h0);
        check({tag, ".imem_addr"}, imem_addr,     32'h0);
        check({tag, ".halted"},    32'(halted),   32'h0);
        check({tag, ".fault"},     32'(fault),    32'h0);
        check({tag, ".fault_pc"},  fault_pc,      32'h0);
    endtask

    function automatic logic [31:0] random_target();
        int unsigned sel;
        sel = $urandom_range(0, 9);
        if (sel <= 6)      return {22'h0, 8'($urandom_range(0, 255)), 2'b00};
        else if (sel == 7) return 32'd1020 - 32'(4 * $urandom_range(0, 3));
        else if (sel == 8) return {22'h0, 8'($urandom_range(0, 255)), 2'($urandom_range(1, 3))};
        else               return 32'd1024 + 32'($urandom_range(0, 1000)) * 32'd4;
    endfunction

    initial begin
        for (int i = 0; i < int'(WORDS); i++) mem[i] = $urandom;
        mem[0] = 32'h0000_0013;
        mem[1] = 32'h0010_0093;
        mem[2] = 32'h0020_0113;
        mem[3] = 32'h0030_8193;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst = 1'b0;
        model_reset();

        // BOOT edge: nothing yet; fetch edge: first instruction
        step();
        check("boot.if_valid", 32'(if_valid), 32'h0);
        step();
        check("first.if_valid", 32'(if_valid), 32'h1);
        check("first.if_pc",    if_pc,         32'h0);
        check("first.if_instr", if_instr,      NOP_INSTR);
        step();
        check("seq.if_pc4", if_pc, 32'd4);
        step();
        check("seq.if_pc8", if_pc, 32'd8);
        step();
        check("seq.if_pc12", if_pc, 32'd12);
        check("seq.if_instr12", if_instr, 32'h0030_8193);

        // Back to word 1, then backpressure for 3 cycles
        redirect = 1'b1; redirect_pc = 32'd4;
        step();
        redirect = 1'b0;
        check("redir.drop", 32'(if_valid), 32'h0);
        step();
        check("redir.if_pc", if_pc, 32'd4);
        if_ready = 1'b0;
        repeat (3) begin
            step();
            check("hold.if_valid",  32'(if_valid), 32'h1);
            check("hold.if_pc",     if_pc,         32'd4);
            check("hold.if_instr",  if_instr,      32'h0010_0093);
            check("hold.imem_addr", imem_addr,     32'd8);
        end
        if_ready = 1'b1;
        step();
        check("resume.if_pc", if_pc, 32'd8);

        // Redirect discards a held, unaccepted instruction
        if_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'd4;
        step();
        redirect = 1'b0;
        step();
        check("held.if_pc", if_pc, 32'd4);
        redirect = 1'b1; redirect_pc = 32'd12;
        step();
        redirect = 1'b0;
        check("discard.if_valid", 32'(if_valid), 32'h0);
        step();
        check("target.if_valid", 32'(if_valid), 32'h1);
        check("target.if_pc",    if_pc,         32'd12);
        check("target.if_instr", if_instr,      32'h0030_8193);

        // Halt while the held instruction is consumed
        if_ready = 1'b1; halt_req = 1'b1;
        step();
        check("halt.halted",    32'(halted),   32'h1);
        check("halt.if_valid",  32'(if_valid), 32'h0);
        check("halt.imem_addr", imem_addr,     32'd16);
        step();
        check("halt.frozen", imem_addr, 32'd16);
        halt_req = 1'b0;
        step();
        check("unhalt.halted", 32'(halted), 32'h0);
        step();
        check("unhalt.if_valid", 32'(if_valid), 32'h1);
        check("unhalt.if_pc",    if_pc,         32'd16);

        // Misaligned redirect faults and stays faulted
        redirect = 1'b1; redirect_pc = 32'h6;
        step();
        redirect = 1'b0;
        check("misalign.fault",    32'(fault),    32'h1);
        check("misalign.fault_pc", fault_pc,      32'h6);
        check("misalign.if_valid", 32'(if_valid), 32'h0);
        repeat (3) begin
            if_ready = 1'($urandom_range(0, 1));
            step();
            check("faulted.if_valid", 32'(if_valid), 32'h0);
            check("faulted.fault",    32'(fault),    32'h1);
        end

        // Asynchronous reset in the middle of a cycle while faulted
        #2 rst = 1'b1;
        #1;
        check_reset_values("midreset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        if_ready = 1'b1;

        // Random traffic against the model
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(0, 9) == 0) halt_req = ~halt_req;
            if_ready    = ($urandom_range(0, 9) < 7);
            redirect    = ($urandom_range(0, 99) < 6);
            redirect_pc = random_target();
            if (m_faulted && $urandom_range(0, 7) == 0) begin
                rst = 1'b1;
                #2;
                rst = 1'b0;
                model_reset();
            end
            step();
        end

        // End of memory on the 4-word instance: no wrap to address 0
        redirect = 1'b0; halt_req = 1'b0; if_ready = 1'b1;
        s_halt_req = 1'b0; s_if_ready = 1'b1;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        model_reset();
        step();
        check("small.boot", 32'(s_if_valid), 32'h0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("small.if_valid", 32'(s_if_valid), 32'h1);
            check("small.if_pc",    s_if_pc,         32'(4 * i));
            check("small.if_instr", s_if_instr,      mem[i]);
        end
        step();
        check("small.fault",    32'(s_fault),    32'h1);
        check("small.fault_pc", s_fault_pc,      32'd16);
        check("small.if_valid", 32'(s_if_valid), 32'h0);
        repeat (3) begin
            step();
            check("small.nowrap", 32'(s_if_valid), 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/fetch_controller.md
# fetch_controller

Instruction-fetch sequencer for the single-cycle-read, word-addressed instruction memory. It owns the program counter, drives the memory address, registers the returned word with its PC, and presents it to decode over a valid/ready handshake. It also handles branch/jump redirects, a halt request, and address faults. It sits between the instruction memory and the decode stage of the RISC-V core.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC loaded at reset.
- IMEM_WORDS, 256, instruction memory depth in 32-bit words. The legal byte range is 0 .. IMEM_WORDS*4-1.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_addr  out  32  byte address to instruction memory; always equals pc.
- imem_instr  in  32  instruction word; combinational from imem_addr, valid in the same cycle.
- if_valid  out  1  if_instr/if_pc hold an unconsumed instruction.
- if_ready  in  1  decode accepts the instruction this cycle when if_valid=1.
- if_instr  out  32  fetched instruction.
- if_pc  out  32  byte address of if_instr.
- redirect  in  1  one-cycle pulse requesting a change of flow.
- redirect_pc  in  32  target address for redirect.
- halt_req  in  1  level; while high, no new fetches are issued.
- halted  out  1  high in HALTED state.
- fault  out  1  sticky; an illegal fetch address was reached.
- fault_pc  out  32  the offending address, captured with fault.

## Operation
- States: BOOT, RUN, HALTED, FAULT.
- Reset, asynchronous: state=BOOT, pc=RESET_PC, if_valid=0, if_instr=0, if_pc=0, halted=0, fault=0, fault_pc=0.
- BOOT goes to RUN unconditionally after one cycle. No fetch is issued in BOOT.
- A slot is free when if_valid=0, or when if_valid=1 and if_ready=1.
- A fetch fires in RUN when the slot is free, halt_req=0, redirect=0 and pc is legal. On a fetch:
  - if_instr<=imem_instr
  - if_pc<=pc
  - if_valid<=1
  - pc<=pc+4
- If the slot is consumed and no fetch fires, if_valid<=0.
- Hold rule: while if_valid=1 and if_ready=0, if_instr and if_pc are stable and pc does not advance.
- Redirect has the highest priority in RUN and HALTED:
  - if_valid<=0; any held or just-accepted instruction is discarded.
  - pc<=redirect_pc.
  - No fetch occurs that cycle.
- Legal address: bits[1:0]==0 and addr < IMEM_WORDS*4.
- Fault:
  - A redirect to an illegal redirect_pc, or a RUN-state fetch attempt at an illegal pc, goes to FAULT.
  - fault<=1 and fault_pc<=that address.
  - if_valid<=0 and no further fetches. Only rst leaves FAULT.
- Sequential wrap: pc=IMEM_WORDS*4-4 fetches normally. The next attempt, at IMEM_WORDS*4, faults. There is no wrap to 0.
- Halt:
  - RUN with halt_req=1 goes to HALTED. The held if_valid instruction stays until accepted; no new fetch.
  - HALTED with halt_req=0 goes to RUN in the next cycle.
  - halted=1 exactly while in HALTED.
- Simultaneous redirect and halt_req: the redirect is applied, and the state follows halt_req.
- pc arithmetic is 32-bit unsigned; the range check runs on the full 32 bits.

## Timing
- Fetch latency: the instruction at pc is registered on the edge that ends the cycle in which imem_addr=pc. if_valid rises one cycle after the fetch cycle.
- First if_valid: the 2nd rising edge after rst deasserts (BOOT edge, then fetch edge).
- Throughput: one instruction per cycle while if_ready=1.
- Redirect to first valid target instruction: 2 edges. Edge 1 loads pc; edge 2 fetches.
- Fault is visible one edge after the illegal redirect or fetch attempt.
- All outputs are registered except imem_addr, which is the pc register output.

## Structure
- Package fetch_pkg:
  - state enum {BOOT, RUN, HALTED, FAULT}, 2 bits.
  - INSTR_BYTES=4.
  - NOP_INSTR=32'h0000_0013.
- Sub-module fetch_addr_check: combinational alignment and range check, parameterised by IMEM_WORDS. It is instantiated twice, once for pc and once for redirect_pc, and is reusable for data-memory checks.
- Everything else lives in fetch_controller: FSM, pc register, output register.

## Test plan
- Reset release, memory words 0..3 = 13/00100093/00200113/00308193 (hex), if_ready=1:
  - if_valid rises at the 2nd edge after release with if_pc=0, if_instr=32'h00000013.
  - Then if_pc=4/8/12 on consecutive cycles.
- Backpressure: if_ready=0 for 3 cycles while if_pc=4. if_instr holds 32'h00100093, imem_addr holds 8, no PC skips. Resume yields if_pc=8.
- Redirect with redirect_pc=12 while if_pc=4 is valid and unaccepted:
  - The if_pc=4 instruction is dropped (if_valid=0 next cycle).
  - The next valid output is if_pc=12, if_instr=32'h00308193.
- Misaligned redirect_pc=32'h6: fault=1, fault_pc=6, if_valid=0 forever until rst. Asserting rst mid-fault restores the BOOT values.
- Halt: halt_req=1 with if_valid=1 and if_ready=1. The instruction is consumed, halted=1 next cycle, pc frozen. halt_req=0 gives halted=0 and fetch resumes at the frozen pc.
- End of memory with IMEM_WORDS=4: if_pc=12 is delivered, then fault=1 with fault_pc=16 and no if_pc=0.
